counter_cmd_sequencer: RTL and testbench

Command-driven control stage sitting directly upstream of the 16-bit up/down counter. It accepts LOAD / COUNT-UP / COUNT-DOWN commands over a valid/ready handshake. It then drives the counter's `ld_cnt`, `updn_cnt`, `count_enb` and `data_in` inputs for the exact number of cycles each command requires, and reports completion with a one-cycle `done` pulse.

---
 rtl/counter_cmd_sequencer_if.sv | 29 ++
 rtl/counter_cmd_sequencer.sv | 149 ++++++++++++++
 tb/tb_counter_cmd_sequencer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/counter_cmd_sequencer_if.sv
// -----------------------------------------------------------------------------
// counter_cmd_sequencer_if
//
// Command channel into the counter command sequencer.
//   cmd_valid  master -> slave  command present
//   cmd_ready  slave  -> master sequencer can accept this cycle
//   cmd_op     master -> slave  00 NOP, 01 LOAD, 10 UP, 11 DOWN
//   cmd_data   master -> slave  LOAD value, or step count in the low bits
//   abort      master -> slave  terminate an in-progress COUNT
// -----------------------------------------------------------------------------
interface counter_cmd_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic             abort;

  modport master (
    output cmd_valid, cmd_op, cmd_data, abort,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, abort,
    output cmd_ready
  );
endinterface

// File: rtl/counter_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// counter_cmd_sequencer
//
// Control stage upstream of a 16-bit up/down counter. Accepts LOAD / UP / DOWN
// commands over a valid/ready channel and drives the counter's load, direction
// and enable inputs for exactly as many cycles as the command needs, then
// pulses done for one cycle.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst_       synchronous active-low reset
//   cmd        command channel (slave side): valid/ready/op/data/abort
//   ld_cnt     to counter, active-low load
//   updn_cnt   to counter, 1 = up, 0 = down
//   count_enb  to counter, active-high count enable
//   data_in    to counter, load value
//   busy       sequencer not idle
//   done       one-cycle completion pulse
// -----------------------------------------------------------------------------
module counter_cmd_sequencer #(
  parameter int WIDTH  = 16,
  parameter int STEP_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_,
  counter_cmd_sequencer_if.slave    cmd,
  output logic                      ld_cnt,
  output logic                      updn_cnt,
  output logic                      count_enb,
  output logic [WIDTH-1:0]          data_in,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_COUNT,
    S_FIN
  } state_e;

  localparam logic [1:0]        OP_NOP  = 2'b00;
  localparam logic [1:0]        OP_LOAD = 2'b01;
  localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
  localparam logic [STEP_W-1:0] STEP_ZERO = '0;

  state_e            state_q, state_d;
  logic [STEP_W-1:0] rem_q, rem_d;
  logic              ld_cnt_q, ld_cnt_d;
  logic              updn_q, updn_d;
  logic              count_enb_q, count_enb_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              accept;
  logic [STEP_W-1:0] steps;

  // Ready is gated by reset so nothing can be accepted on a reset edge.
  assign cmd.cmd_ready = (state_q == S_IDLE) && rst_;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign steps         = cmd.cmd_data[STEP_W-1:0];

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      ld_cnt_q    <= 1'b1;
      updn_q      <= 1'b0;
      count_enb_q <= 1'b0;
      data_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      ld_cnt_q    <= ld_cnt_d;
      updn_q      <= updn_d;
      count_enb_q <= count_enb_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (cmd.cmd_op == OP_NOP) begin
            state_d = S_FIN;
          end else if (cmd.cmd_op == OP_LOAD) begin
            state_d = S_LOAD;
          end else if (steps != STEP_ZERO) begin
            state_d = S_COUNT;
            rem_d   = steps;
          end else begin
            state_d = S_FIN;
          end
        end
      end
      S_LOAD:  state_d = S_FIN;
      S_COUNT: begin
        // The abort-sampling edge is itself a counted step: enable was high
        // throughout the cycle leading up to it.
        rem_d = rem_q - STEP_ONE;
        if (rem_q == STEP_ONE || cmd.abort) state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode: outputs are computed from the next state and registered,
  // so the counter sees glitch-free levels aligned with the state register.
  // ---------------------------------------------------------------------------
  always_comb begin
    ld_cnt_d    = (state_d != S_LOAD);
    count_enb_d = (state_d == S_COUNT);
    done_d      = (state_d == S_FIN);
    busy_d      = (state_d != S_IDLE);
    updn_d      = updn_q;
    data_d      = data_q;
    // Direction and load value change only on entry; they hold otherwise.
    if (state_q == S_IDLE && state_d == S_COUNT) updn_d = ~cmd.cmd_op[0];
    if (state_q == S_IDLE && state_d == S_LOAD)  data_d = cmd.cmd_data;
  end

  assign ld_cnt    = ld_cnt_q;
  assign updn_cnt  = updn_q;
  assign count_enb = count_enb_q;
  assign data_in   = data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_counter_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_counter_cmd_sequencer
//
// Drives directed commands into the sequencer, models the downstream 16-bit
// counter, and scores each done pulse against a queued expectation.
// -----------------------------------------------------------------------------
module tb_counter_cmd_sequencer;
  localparam int WIDTH  = 16;
  localparam int STEP_W = 8;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_UP   = 2'b10;
  localparam logic [1:0] OP_DOWN = 2'b11;

  logic             clk = 1'b0;
  logic             rst_;
  logic             ld_cnt, updn_cnt, count_enb, busy, done;
  logic [WIDTH-1:0] data_in;

  counter_cmd_sequencer_if #(.WIDTH(WIDTH)) cmd_if ();

  counter_cmd_sequencer #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
    .clk       (clk),
    .rst_      (rst_),
    .cmd       (cmd_if.slave),
    .ld_cnt    (ld_cnt),
    .updn_cnt  (updn_cnt),
    .count_enb (count_enb),
    .data_in   (data_in),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Downstream counter model.
  logic [WIDTH-1:0] cnt_q;
  always @(posedge clk) begin
    if (ld_cnt === 1'b0)         cnt_q <= data_in;
    else if (count_enb === 1'b1) cnt_q <= (updn_cnt === 1'b1) ? cnt_q + 16'd1 : cnt_q - 16'd1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  typedef struct {
    int          lat;
    int          n_ld;
    int          n_cnt;
    int          n_up;
    logic [15:0] ld_data;
    logic [15:0] val;
    int          acc;
  } exp_t;

  exp_t sb_q[$];

  function automatic exp_t mk(int lat, int n_ld, int n_cnt, int n_up,
                              logic [15:0] ld_data, logic [15:0] val);
    exp_t e;
    e.lat = lat; e.n_ld = n_ld; e.n_cnt = n_cnt; e.n_up = n_up;
    e.ld_data = ld_data; e.val = val; e.acc = 0;
    return e;
  endfunction

  // Monitor: samples on the falling edge, scores on every done cycle.
  int          m_ld, m_cnt, m_up;
  logic [15:0] m_ld_data;
  exp_t        m_e;
  always @(negedge clk) begin
    if (rst_ !== 1'b1) begin
      m_ld = 0; m_cnt = 0; m_up = 0; m_ld_data = '0;
    end else begin
      check("ld_enb_exclusive", {31'b0, (ld_cnt === 1'b0) && (count_enb === 1'b1)}, 32'd0);
      if (ld_cnt === 1'b0) begin m_ld++; m_ld_data = data_in; end
      if (count_enb === 1'b1) begin m_cnt++; if (updn_cnt === 1'b1) m_up++; end
      if (done === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          m_e = sb_q.pop_front();
          check("done_latency", cyc - m_e.acc, m_e.lat);
          check("ld_cycles",    m_ld,  m_e.n_ld);
          check("enb_cycles",   m_cnt, m_e.n_cnt);
          check("up_cycles",    m_up,  m_e.n_up);
          if (m_e.n_ld > 0) check("ld_data", m_ld_data, m_e.ld_data);
          check("counter_value", cnt_q, m_e.val);
        end
        m_ld = 0; m_cnt = 0; m_up = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one command; returns just after the accept edge.
  task automatic issue(input logic [1:0] op, input logic [15:0] data,
                       input exp_t e, input bit push);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_data  = data;
    for (int i = 0; i < 50 && cmd_if.cmd_ready !== 1'b1; i++) step();
    if (cmd_if.cmd_ready !== 1'b1) begin
      check("ready_timeout", {31'b0, cmd_if.cmd_ready}, 32'd1);
      cmd_if.cmd_valid = 1'b0;
      return;
    end
    e.acc = cyc + 1;
    if (push) sb_q.push_back(e);
    step();
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = OP_NOP;
    cmd_if.cmd_data  = 16'h0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 1000 && (sb_q.size() != 0 || busy !== 1'b0); i++) step();
    check("drain", {31'b0, (sb_q.size() == 0) && (busy === 1'b0)}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ld_cnt"},    {31'b0, ld_cnt},    32'd1);
    check({tag, "_count_enb"}, {31'b0, count_enb}, 32'd0);
    check({tag, "_updn_cnt"},  {31'b0, updn_cnt},  32'd0);
    check({tag, "_data_in"},   {16'b0, data_in},   32'd0);
    check({tag, "_done"},      {31'b0, done},      32'd0);
    check({tag, "_busy"},      {31'b0, busy},      32'd0);
    check({tag, "_cmd_ready"}, {31'b0, cmd_if.cmd_ready}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held for two cycles with a LOAD offered; it must not be taken.
    rst_             = 1'b0;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = OP_LOAD;
    cmd_if.cmd_data  = 16'h1234;
    cmd_if.abort     = 1'b0;
    step();
    check_reset_outputs("rst1");
    step();
    check_reset_outputs("rst2");
    rst_             = 1'b1;
    cmd_if.cmd_valid = 1'b0;
    #1;
    check("ready_after_rst", {31'b0, cmd_if.cmd_ready}, 32'd1);
    step();
    check("idle_after_rst", {31'b0, busy}, 32'd0);

    // LOAD 0xA5A5.
    issue(OP_LOAD, 16'hA5A5, mk(1, 1, 0, 0, 16'hA5A5, 16'hA5A5), 1'b1);
    wait_done();

    // LOAD 0xFFFE then UP 5: wraps to 0x0003.
    issue(OP_LOAD, 16'hFFFE, mk(1, 1, 0, 0, 16'hFFFE, 16'hFFFE), 1'b1);
    wait_done();
    issue(OP_UP, 16'h0005, mk(5, 0, 5, 5, 16'h0, 16'h0003), 1'b1);
    wait_done();

    // DOWN with step field 0 (upper bits set): immediate done, no counting.
    issue(OP_DOWN, 16'h0100, mk(0, 0, 0, 0, 16'h0, 16'h0003), 1'b1);
    wait_done();
    check("updn_hold", {31'b0, updn_cnt}, 32'd1);
    check("data_in_hold", {16'b0, data_in}, 32'h0000_FFFE);

    // LOAD 0x0064 then DOWN 200 aborted in the 10th count cycle.
    issue(OP_LOAD, 16'h0064, mk(1, 1, 0, 0, 16'h0064, 16'h0064), 1'b1);
    wait_done();
    issue(OP_DOWN, 16'd200, mk(10, 0, 10, 0, 16'h0, 16'h005A), 1'b1);
    repeat (9) step();
    cmd_if.abort = 1'b1;
    step();
    cmd_if.abort = 1'b0;
    wait_done();

    // UP 50 with reset sampled at the end of the 3rd count cycle.
    issue(OP_UP, 16'd50, mk(0, 0, 0, 0, 16'h0, 16'h0), 1'b0);
    repeat (2) step();
    rst_ = 1'b0;
    step();
    check_reset_outputs("mid_rst");
    check("counter_after_rst", {16'b0, cnt_q}, 32'h0000_005D);
    rst_ = 1'b1;
    #1;
    check("ready_after_mid_rst", {31'b0, cmd_if.cmd_ready}, 32'd1);

    // A new command is accepted after release.
    issue(OP_NOP, 16'h0000, mk(0, 0, 0, 0, 16'h0, 16'h005D), 1'b1);
    wait_done();
    repeat (3) step();

    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
